// File: rtl/ysyx_2022040010_mem_arbiter.sv
// ysyx_2022040010_mem_arbiter
// Shares the core's single memory-bus port between the instruction-fetch
// side (I) and the data side (D). One transaction is outstanding at a time:
// the winner's fields are latched onto the bus, held until the bridge's
// refresh pulse, then the read data and a one-cycle done pulse are returned
// to the owner.
//
// Build option: define YSYX_2022040010_ARB_RR_EN for round-robin arbitration
// between the two sides. Without it the D-side wins every conflict.
module ysyx_2022040010_mem_arbiter (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_done,
    output logic [63:0] if_rdata,

    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_uncache,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    input  logic [7:0]  d_wsel,
    output logic        d_done,
    output logic [63:0] d_rdata,

    output logic        bus_e,
    output logic        bus_we,
    output logic        bus_uncache,
    output logic [63:0] bus_addr,
    output logic [63:0] bus_wdata,
    output logic [7:0]  bus_wsel,
    input  logic        refresh,
    input  logic [63:0] bus_rdata,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic        owner_q;        // 0 = I-side owns the bus, 1 = D-side
    logic        bus_e_q;
    logic        bus_we_q;
    logic        bus_uncache_q;
    logic [63:0] bus_addr_q;
    logic [63:0] bus_wdata_q;
    logic [7:0]  bus_wsel_q;
    logic        if_done_q;
    logic        d_done_q;
    logic [63:0] if_rdata_q;
    logic [63:0] d_rdata_q;
    logic        win_dside;      // arbitration result, meaningful only in IDLE

`ifdef YSYX_2022040010_ARB_RR_EN
    logic        last_q;         // owner of the previous grant, 0 = I-side

    // On a conflict hand the bus to the side that did not have it last time.
    always_comb begin
        win_dside = d_req;
        if (if_req && d_req) begin
            win_dside = ~last_q;
        end
    end
`else
    // Fixed priority: any D-side request beats the I-side.
    assign win_dside = d_req;
`endif

    // Arbiter FSM: grant in IDLE, hold the bus in BUSY, pulse done in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            owner_q       <= 1'b0;
            bus_e_q       <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_uncache_q <= 1'b0;
            bus_addr_q    <= 64'd0;
            bus_wdata_q   <= 64'd0;
            bus_wsel_q    <= 8'd0;
            if_done_q     <= 1'b0;
            d_done_q      <= 1'b0;
            if_rdata_q    <= 64'd0;
            d_rdata_q     <= 64'd0;
`ifdef YSYX_2022040010_ARB_RR_EN
            last_q        <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if_done_q <= 1'b0;
                    d_done_q  <= 1'b0;
                    if (if_req || d_req) begin
                        owner_q <= win_dside;
                        bus_e_q <= 1'b1;
                        state_q <= BUSY;
`ifdef YSYX_2022040010_ARB_RR_EN
                        last_q  <= win_dside;
`endif
                        if (win_dside) begin
                            bus_we_q      <= d_we;
                            bus_uncache_q <= d_uncache;
                            bus_addr_q    <= d_addr;
                            bus_wdata_q   <= d_wdata;
                            bus_wsel_q    <= d_wsel;
                        end else begin
                            // Instruction fetch is always a full-width cached read.
                            bus_we_q      <= 1'b0;
                            bus_uncache_q <= 1'b0;
                            bus_addr_q    <= if_addr;
                            bus_wdata_q   <= 64'd0;
                            bus_wsel_q    <= 8'hFF;
                        end
                    end else begin
                        bus_e_q       <= 1'b0;
                        bus_we_q      <= 1'b0;
                        bus_uncache_q <= 1'b0;
                        bus_addr_q    <= 64'd0;
                        bus_wdata_q   <= 64'd0;
                        bus_wsel_q    <= 8'd0;
                    end
                end
                BUSY: begin
                    // Requester inputs are deliberately ignored here so a
                    // request dropped mid-flight still runs to completion.
                    if (refresh) begin
                        bus_e_q <= 1'b0;
                        state_q <= RESP;
                        if (owner_q) begin
                            d_rdata_q <= bus_rdata;
                            d_done_q  <= 1'b1;
                        end else begin
                            if_rdata_q <= bus_rdata;
                            if_done_q  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if_done_q <= 1'b0;
                    d_done_q  <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus_e       = bus_e_q;
    assign bus_we      = bus_we_q;
    assign bus_uncache = bus_uncache_q;
    assign bus_addr    = bus_addr_q;
    assign bus_wdata   = bus_wdata_q;
    assign bus_wsel    = bus_wsel_q;
    assign if_done     = if_done_q;
    assign d_done      = d_done_q;
    assign if_rdata    = if_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_ysyx_2022040010_mem_arbiter.sv
// Testbench for ysyx_2022040010_mem_arbiter.
// Requester tasks push each issued request into a per-side queue, the bridge
// model pushes the read data it returns, and a negedge monitor pops and
// compares whenever the arbiter grants the bus or pulses a done.
module tb_ysyx_2022040010_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [63:0] if_addr = 64'd0;
    logic        if_done;
    logic [63:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic        d_uncache = 1'b0;
    logic [63:0] d_addr = 64'd0;
    logic [63:0] d_wdata = 64'd0;
    logic [7:0]  d_wsel = 8'd0;
    logic        d_done;
    logic [63:0] d_rdata;
    logic        bus_e;
    logic        bus_we;
    logic        bus_uncache;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wsel;
    logic        refresh = 1'b0;
    logic [63:0] bus_rdata = 64'd0;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic        we;
        logic        unc;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wsel;
    } req_t;

    req_t        iq[$];
    req_t        dq[$];
    logic [63:0] rq[$];
    bit          glog[$];

    ysyx_2022040010_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_uncache(d_uncache), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_wsel(d_wsel), .d_done(d_done), .d_rdata(d_rdata),
        .bus_e(bus_e), .bus_we(bus_we), .bus_uncache(bus_uncache), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wsel(bus_wsel), .refresh(refresh),
        .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [137:0] act, input logic [137:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // ---------------- bridge model ----------------
    int          fixed_lat   = -1;
    bit          stray_en    = 1'b0;
    bit          fixed_rd_en = 1'b0;
    logic [63:0] fixed_rdata = 64'd0;

    initial begin : bridge
        int cnt;
        bit active;
        active = 1'b0;
        cnt    = 0;
        forever begin
            tick();
            refresh = 1'b0;
            if (!rst) begin
                active = 1'b0;
            end else if (bus_e) begin
                if (!active) begin
                    active = 1'b1;
                    cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
                end
                if (cnt == 0) begin
                    refresh   = 1'b1;
                    bus_rdata = fixed_rd_en ? fixed_rdata : {$urandom, $urandom};
                    rq.push_back(bus_rdata);
                    active    = 1'b0;
                end else begin
                    cnt--;
                end
            end else begin
                active = 1'b0;
                if (stray_en && $urandom_range(0, 5) == 0) begin
                    refresh   = 1'b1;
                    bus_rdata = {$urandom, $urandom};
                end
            end
        end
    end

    // ---------------- monitor / reference model ----------------
    bit          mon_en = 1'b0;
    bit          m_busy, m_idle_prev, p_refresh, p_ifreq, p_dreq;
    bit          m_owner, m_d_known;
    bit          g_now, resp_now, busy_now;
    req_t        m_cur, exp_r, act_r;
    logic [63:0] m_if_rd = 64'd0;
    logic [63:0] m_d_rd  = 64'd0;
    logic [63:0] rd_pop;
`ifdef YSYX_2022040010_ARB_RR_EN
    bit          m_last;
`endif

    always @(negedge clk) begin
        if (!mon_en || !rst) begin
            m_busy      = 1'b0;
            m_idle_prev = 1'b1;
            p_refresh   = 1'b0;
            p_ifreq     = 1'b0;
            p_dreq      = 1'b0;
`ifdef YSYX_2022040010_ARB_RR_EN
            m_last      = 1'b0;
`endif
        end else begin
            // A request seen in an idle cycle is granted in the next one;
            // refresh during a bus phase yields done in the next cycle.
            g_now    = m_idle_prev && (p_ifreq || p_dreq);
            resp_now = m_busy && p_refresh;
            busy_now = g_now || (m_busy && !p_refresh);
            act_r    = {bus_we, bus_uncache, bus_addr, bus_wdata, bus_wsel};
            if (g_now) begin
`ifdef YSYX_2022040010_ARB_RR_EN
                m_owner = (p_ifreq && p_dreq) ? !m_last : p_dreq;
                m_last  = m_owner;
`else
                m_owner = p_dreq;
`endif
                glog.push_back(m_owner);
                check("grant_bus_e", bus_e, 1'b1);
                exp_r = '0;
                if (m_owner) begin
                    if (dq.size() > 0) exp_r = dq.pop_front();
                    else check("grant_d_no_request", dq.size(), 1);
                    check("grant_d_fields", act_r, exp_r);
                end else begin
                    if (iq.size() > 0) exp_r = iq.pop_front();
                    else check("grant_i_no_request", iq.size(), 1);
                    check("grant_i_fields", act_r, exp_r);
                end
                m_cur = exp_r;
            end else if (busy_now) begin
                check("bus_hold", {bus_e, act_r}, {1'b1, m_cur});
            end else begin
                check("bus_e_low", bus_e, 1'b0);
            end

            if (resp_now) begin
                check("done_owner", {if_done, d_done}, {!m_owner, m_owner});
                rd_pop = 64'd0;
                if (rq.size() > 0) rd_pop = rq.pop_front();
                else check("resp_no_rdata", rq.size(), 1);
                if (m_owner) begin
                    m_d_known = !m_cur.we;
                    m_d_rd    = rd_pop;
                end else begin
                    m_if_rd = rd_pop;
                end
            end else begin
                check("no_done", {if_done, d_done}, 2'b00);
            end
            check("if_rdata", if_rdata, m_if_rd);
            if (m_d_known) check("d_rdata", d_rdata, m_d_rd);
            check("busy", busy, busy_now || resp_now);

            m_busy      = busy_now;
            m_idle_prev = !busy_now && !resp_now;
            p_refresh   = refresh;
            p_ifreq     = if_req;
            p_dreq      = d_req;
        end
    end

    // ---------------- requesters ----------------
    task automatic i_txn(input logic [63:0] a);
        int w;
        if_addr = a;
        if_req  = 1'b1;
        iq.push_back({1'b0, 1'b0, a, 64'd0, 8'hFF});
        w = 0;
        do begin
            tick();
            w++;
        end while (!if_done && w < 200);
        if (!if_done) check("i_done_timeout", if_done, 1'b1);
        if_req = 1'b0;
    endtask

    task automatic d_txn(input logic we, input logic unc, input logic [63:0] a,
                         input logic [63:0] wd, input logic [7:0] ws, input bit drop);
        int w;
        d_we      = we;
        d_uncache = unc;
        d_addr    = a;
        d_wdata   = wd;
        d_wsel    = ws;
        d_req     = 1'b1;
        dq.push_back({we, unc, a, wd, ws});
        w = 0;
        if (drop) begin
            do begin
                tick();
                w++;
            end while (!(bus_e && bus_addr == a) && w < 200);
            d_req = 1'b0;
        end
        do begin
            tick();
            w++;
        end while (!d_done && w < 400);
        if (!d_done) check("d_done_timeout", d_done, 1'b1);
        d_req = 1'b0;
    endtask

    task automatic i_random(input int n);
        logic [63:0] a;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) tick();
            a = {$urandom, $urandom};
            a[63] = 1'b0;
            a[2:0] = 3'd0;
            i_txn(a);
        end
    endtask

    task automatic d_random(input int n);
        logic [63:0] a;
        for (int t = 0; t < n; t++) begin
            repeat ($urandom_range(0, 3)) tick();
            a = {$urandom, $urandom};
            a[63] = 1'b1;
            d_txn($urandom_range(0, 1), $urandom_range(0, 1), a, {$urandom, $urandom},
                  8'($urandom), ($urandom_range(0, 3) == 0));
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sz;
        #1 rst = 1'b0;
        #3;
        check("reset_outputs",
              {bus_e, bus_we, bus_uncache, bus_addr, bus_wsel, if_done, d_done, busy},
              '0);
        check("reset_rdata", {if_rdata, d_rdata}, '0);
        @(posedge clk);
        #2 rst = 1'b1;
        m_if_rd   = 64'd0;
        m_d_rd    = 64'd0;
        m_d_known = 1'b1;
        mon_en    = 1'b1;
        tick();

        // single I-side read, refresh four cycles into the transaction
        fixed_lat   = 3;
        fixed_rd_en = 1'b1;
        fixed_rdata = 64'h0000_0013_0000_0093;
        i_txn(64'h0000_0000_8000_0000);
        check("i_read_rdata", if_rdata, 64'h0000_0013_0000_0093);
        tick();

        // uncached D-side write
        fixed_rd_en = 1'b0;
        fixed_lat   = 1;
        d_txn(1'b1, 1'b1, 64'h0000_0000_A000_03F8, 64'h41, 8'h01, 1'b0);
        tick();

        // simultaneous requests, each held until its own done
        fixed_lat = 2;
        fork
            i_txn(64'h0000_0000_8000_1000);
            d_txn(1'b0, 1'b0, 64'h8000_0000_0000_2000, 64'd0, 8'hFF, 1'b0);
        join
        sz = glog.size();
        if (sz >= 2) begin
`ifdef YSYX_2022040010_ARB_RR_EN
            check("conflict_first", glog[sz-2], 1'b0);
            check("conflict_second", glog[sz-1], 1'b1);
`else
            check("conflict_first", glog[sz-2], 1'b1);
            check("conflict_second", glog[sz-1], 1'b0);
`endif
        end else begin
            check("conflict_grants", sz, 2);
        end
        tick();

        // stray refresh pulses while idle, then a D read dropped mid-flight
        stray_en = 1'b1;
        repeat (12) tick();
        fixed_lat = 4;
        d_txn(1'b0, 1'b0, 64'h8000_0000_0000_3000, 64'd0, 8'hFF, 1'b1);
        tick();

        // randomized traffic from both sides
        fixed_lat = -1;
        fork
            i_random(40);
            d_random(40);
        join
        repeat (4) tick();
        stray_en = 1'b0;
        check("queues_drained", {iq.size(), dq.size()}, '0);

        // reset in the middle of a transaction
        mon_en  = 1'b0;
        fixed_lat = 6;
        if_addr = 64'h0000_0000_8000_4000;
        if_req  = 1'b1;
        begin
            int w;
            w = 0;
            do begin
                tick();
                w++;
            end while (!bus_e && w < 20);
        end
        check("pre_reset_busy", {bus_e, busy}, 2'b11);
        #1 rst = 1'b0;
        #1;
        check("async_reset_ctrl", {bus_e, if_done, d_done, busy}, 4'b0000);
        check("async_reset_rdata", {if_rdata, d_rdata}, '0);
        check("async_reset_bus", {bus_addr, bus_wsel}, '0);
        @(posedge clk);
        #2 rst = 1'b1;
        check("post_reset_idle", bus_e, 1'b0);
        tick();
        check("post_reset_grant", {bus_e, bus_addr}, {1'b1, 64'h0000_0000_8000_4000});
        if_req = 1'b0;
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_2022040010_mem_arbiter.md
# ysyx_2022040010_mem_arbiter

Shares the single memory-bus port of the core between the instruction-fetch requester (I-side) and the data requester (D-side, cached refill or uncached access). It sits between the fetch/LSU front ends and the AXI bridge. It selects one requester, holds that request stable on the bus until the bridge's `refresh` completion pulse, then returns read data and a one-cycle done pulse to the granted side.

## Interface
- No parameters; widths fixed: address 64, data 64, byte-select 8.
- `clk` in 1 — core clock, rising edge.
- `rst` in 1 — asynchronous, active-low reset.
- `if_req` in 1 — I-side request. Held high until `if_done`.
- `if_addr` in 64 — I-side address. Always a read.
- `if_done` out 1 — one-cycle pulse; `if_rdata` valid.
- `if_rdata` out 64 — I-side read data.
- `d_req` in 1 — D-side request. Held high until `d_done`.
- `d_we` in 1 — D-side write enable.
- `d_uncache` in 1 — D-side uncached access.
- `d_addr` in 64 — D-side address.
- `d_wdata` in 64 — D-side write data.
- `d_wsel` in 8 — D-side byte strobes.
- `d_done` out 1 — one-cycle pulse; `d_rdata` valid.
- `d_rdata` out 64 — D-side read data.
- `bus_e` out 1 — bus request, held until `refresh`.
- `bus_we` out 1 — write enable.
- `bus_uncache` out 1 — uncached flag.
- `bus_addr` out 64 — address.
- `bus_wdata` out 64 — write data.
- `bus_wsel` out 8 — byte strobes.
- `refresh` in 1 — bridge completion pulse; `bus_rdata` valid in the same cycle.
- `bus_rdata` in 64 — read data from the bridge.
- `busy` out 1 — high in BUSY and RESP.

## Operation
- FSM with three states: IDLE, BUSY, RESP. Reset state is IDLE. Every output resets to 0.
- **IDLE**
  - If neither request is high: stay in IDLE, all `bus_*` = 0.
  - Otherwise: pick a winner and register its fields into the `bus_*` registers.
  - For an I-side win: `bus_we`=0, `bus_uncache`=0, `bus_wsel`=8'hFF, `bus_wdata`=0.
  - Record the owner, set `bus_e`=1, go to BUSY.
- **BUSY**
  - All `bus_*` outputs stay frozen.
  - On `refresh`: capture `bus_rdata` into the owner's rdata register, clear `bus_e`, go to RESP.
  - Requester inputs are not re-sampled. A request dropped mid-transaction still completes, and its done pulse is still issued.
- **RESP**
  - Pulse the owner's done signal for exactly one cycle, then go to IDLE.
  - The owner's rdata register holds its value until that owner's next completion.
  - For a write, rdata is undefined.
- **Arbitration** (both requesting in IDLE): defined under Configuration.
- `refresh` outside BUSY is ignored: no state change, no data capture.
- Only one transaction is ever outstanding. The two done signals are never high together.

## Timing
- Request first high in IDLE at cycle 0 → `bus_e`=1 from cycle 1.
- `refresh` at cycle k → `bus_e`=0 and owner done=1 in cycle k+1.
- FSM returns to IDLE at cycle k+2. The earliest next `bus_e` is cycle k+3.
- Minimum turnaround is 3 cycles (`refresh` in cycle 1).
- A requester must drop `req` in the cycle after its done pulse, or it is treated as a new request at cycle k+2.
- Asserting `rst` at any time forces IDLE and zeroes all outputs immediately. An in-flight bus transaction is abandoned; the bridge is reset by the same `rst`.

## Configuration
- `YSYX_2022040010_ARB_RR_EN` **defined**: round-robin arbitration.
  - A 1-bit last-owner register resets to I-side.
  - On a conflict, grant the side that did not own the previous transaction.
  - The register updates on every grant.
- `YSYX_2022040010_ARB_RR_EN` **undefined**: fixed priority.
  - D-side always wins a conflict; the I-side waits.
  - No last-owner register is implemented.

## Test plan
- **Single I-side read**
  - Stimulus: `if_req`=1, `if_addr`=0x8000_0000, `refresh` 4 cycles later with `bus_rdata`=0x0000_0013_0000_0093.
  - Required: `bus_e` for cycles 1–4, `bus_addr`=0x8000_0000, `bus_wsel`=0xFF; `if_done` pulse in cycle 5 with that rdata; `d_done` stays 0.
- **Uncached D-side write**
  - Stimulus: `d_req`=1, `d_we`=1, `d_uncache`=1, `d_addr`=0xA000_03F8, `d_wdata`=0x41, `d_wsel`=0x01.
  - Required: the bus carries exactly these values until `refresh`; `d_done` in the next cycle.
- **Simultaneous requests, fixed priority (macro off)**
  - Stimulus: both requests high, both requesters hold their request until their own done, every `refresh` 2 cycles after `bus_e` rises.
  - Required: D-side is served first; the I-side is granted at `d_done`+1.
- **Simultaneous requests, round-robin (macro on)**
  - Stimulus: both requesters hold their request continuously for three transactions, then both drop it.
  - Required: grants go I, D, I.
- **Stray `refresh` and dropped request**
  - Stimulus: `refresh` pulsed in IDLE; then `d_req` dropped while in BUSY.
  - Required: no state change or data capture for the stray pulse; the D-side transaction still completes with `d_done`=1.
- **Reset mid-transaction**
  - Stimulus: `rst`=0 while in BUSY.
  - Required: `bus_e`, both done signals, `busy` and both rdata outputs go to 0 without waiting for a clock edge.
  - After `rst` returns high with `if_req`=1, `bus_e` rises after one cycle.
